// File: rtl/bit_word_packer.sv
// bit_word_packer: packs variable-length codes (0..32 bits, LSB-aligned) into
// 32-bit words, oldest bit first. Code lengths above 32 are clamped to 32.
// A code with in_last set starts a flush. The flush emits the remaining bits
// as a left-aligned, zero-padded final word marked with out_last.
// Optional build macro: OUT_BYTE_SWAP_EN byte-reverses out_data so that the
// oldest byte lands in out_data[7:0].
module bit_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [5:0]  in_len,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_last
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ACC_W    = 128;
  localparam int unsigned FILL_W   = 8;
  localparam int unsigned LEN_W    = 6;
  localparam int unsigned IN_LIMIT = 96;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ACC_W-1:0]    acc;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_next;
  logic [LEN_W-1:0]    eff_len;
  logic [WORD_W-1:0]   code_bits;
  logic [WORD_W-1:0]   full_word;
  logic [WORD_W-1:0]   tail_word;
  logic [WORD_W-1:0]   word_msb;
  logic                in_hs;
  logic                out_hs;

  // Clamp the code length to 32 and drop code bits at or above it
  always_comb begin
    eff_len   = (in_len > LEN_W'(32)) ? LEN_W'(32) : in_len;
    code_bits = in_data & WORD_W'((33'd1 << eff_len) - 33'd1);
  end

  // Candidate output words: next 32 oldest bits, or the remainder left-aligned
  always_comb begin
    full_word = WORD_W'(acc >> (fill - FILL_W'(32)));
    tail_word = acc[WORD_W-1:0] << (LEN_W'(32) - fill[LEN_W-1:0]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: enter flush after absorbing the last code, leave on the final word
  always_comb begin
    state_next = state;
    case (state)
      RUN:   if (in_hs && in_last)    state_next = FLUSH;
      FLUSH: if (out_hs && out_last)  state_next = RUN;
    endcase
  end

  // Outputs decoded from registered state; all quiet while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bytes = 3'd0;
    out_last  = 1'b0;
    word_msb  = '0;
    if (!reset) begin
      case (state)
        RUN: begin
          in_ready = (fill <= FILL_W'(IN_LIMIT));
          if (fill >= FILL_W'(32)) begin
            out_valid = 1'b1;
            word_msb  = full_word;
            out_bytes = 3'd4;
          end
        end
        FLUSH: begin
          out_valid = 1'b1;
          if (fill > FILL_W'(32)) begin
            word_msb  = full_word;
            out_bytes = 3'd4;
          end else begin
            word_msb  = tail_word;
            out_bytes = 3'((fill + FILL_W'(7)) >> 3);
            out_last  = 1'b1;
          end
        end
      endcase
    end
`ifdef OUT_BYTE_SWAP_EN
    out_data = {word_msb[7:0], word_msb[15:8], word_msb[23:16], word_msb[31:24]};
`else
    out_data = word_msb;
`endif
  end

  // Handshakes and fill bookkeeping; simultaneous accept and emit net out in one step
  always_comb begin
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
    fill_next = fill;
    if (in_hs) begin
      fill_next = fill_next + FILL_W'(eff_len);
    end
    if (out_hs) begin
      fill_next = fill_next - FILL_W'(32);
    end
  end

  // Accumulator and fill count; the final word's handshake empties everything
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      fill <= '0;
    end else if (out_hs && out_last) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      if (in_hs) begin
        acc <= (acc << eff_len) | ACC_W'(code_bits);
      end
      fill <= fill_next;
    end
  end

endmodule
